// File: rtl/subcells_serial_ctrl.sv
// Serial SubCells engine: a 128-bit state is substituted LANES nibbles per cycle through shared S-box lanes.
// Optional build macro SUBCELLS_INV_EN adds inverse S-box lanes selected by in_inv.

module sbox (
    input  logic [3:0] x,
    output logic [3:0] y
);
    // 4-bit forward S-box
    always_comb begin
        y = 4'h0;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            4'hF: y = 4'h2;
            default: y = 4'h0;
        endcase
    end
endmodule

`ifdef SUBCELLS_INV_EN
module invsbox (
    input  logic [3:0] x,
    output logic [3:0] y
);
    // Inverse of sbox
    always_comb begin
        y = 4'h0;
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            4'hF: y = 4'hA;
            default: y = 4'h0;
        endcase
    end
endmodule
`endif

module subcells_serial_ctrl #(
    parameter int unsigned LANES = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int unsigned DW    = 128;
    localparam int unsigned CHW   = 4 * LANES;
    localparam int unsigned BEATS = 32 / LANES;
    localparam int unsigned CW    = $clog2(BEATS) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] work_q, work_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] out_data_d;
    logic [CHW-1:0] chunk, fwd_chunk, sub_chunk;
    logic [DW-1:0] stepped;

    assign chunk = work_q[CHW-1:0];

    // Shared substitution lanes, reused on every beat
    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        sbox u_sbox (.x(chunk[4*i +: 4]), .y(fwd_chunk[4*i +: 4]));
    end

`ifdef SUBCELLS_INV_EN
    logic           inv_q, inv_d;
    logic [CHW-1:0] inv_chunk;

    for (genvar i = 0; i < int'(LANES); i++) begin : g_inv_lane
        invsbox u_invsbox (.x(chunk[4*i +: 4]), .y(inv_chunk[4*i +: 4]));
    end

    assign sub_chunk = inv_q ? inv_chunk : fwd_chunk;
`else
    logic unused_in_inv;

    assign unused_in_inv = in_inv;
    assign sub_chunk     = fwd_chunk;
`endif

    // Rotate: substituted low chunk re-enters at the top, so after BEATS steps order is restored
    if (CHW == DW) begin : g_full
        assign stepped = sub_chunk;
    end else begin : g_part
        assign stepped = {sub_chunk, work_q[DW-1:CHW]};
    end

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        out_data_d = out_data;
`ifdef SUBCELLS_INV_EN
        inv_d      = inv_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_RUN;
                    work_d  = in_data;
                    cnt_d   = '0;
`ifdef SUBCELLS_INV_EN
                    inv_d   = in_inv;
`endif
                end
            end
            S_RUN: begin
                work_d = stepped;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(BEATS - 1)) begin
                    state_d    = S_DONE;
                    out_data_d = stepped;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d    = S_IDLE;
                    out_data_d = '0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                out_data_d = '0;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef SUBCELLS_INV_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            in_ready  <= (state_d == S_IDLE);
            busy      <= (state_d == S_RUN);
            out_valid <= (state_d == S_DONE);
            out_data  <= out_data_d;
`ifdef SUBCELLS_INV_EN
            inv_q     <= inv_d;
`endif
        end
    end

endmodule

// File: tb/tb_subcells_serial_ctrl.sv
// Randomised bench for subcells_serial_ctrl: one DUT per LANES value, each checked every cycle against a transaction-level model.

module tb_subcells_serial_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] KAT_IN  = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] KAT_OUT = 128'hC56B90AD3EF84712_21748FE3DA09B65C;
    localparam logic [127:0] ZERO_OUT = {32{4'hC}};

    function automatic logic [3:0] fwd4(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] inv4(input logic [3:0] x);
        for (int v = 0; v < 16; v++)
            if (fwd4(4'(v)) == x) return 4'(v);
        return 4'h0;
    endfunction

    function automatic logic [127:0] subcells(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        for (int i = 0; i < 32; i++)
            r[4*i +: 4] = inv ? inv4(d[4*i +: 4]) : fwd4(d[4*i +: 4]);
        return r;
    endfunction

    function automatic logic eff_inv(input logic inv);
`ifdef SUBCELLS_INV_EN
        return inv;
`else
        return 1'b0 & inv;
`endif
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int L = 4 << g;
        localparam int N = 32 / L;

        logic         rst_n = 1'b0;
        logic         in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b1;
        logic         in_ready, out_valid, busy;
        logic [127:0] in_data = '0, out_data;
        bit           fin = 1'b0;

        subcells_serial_ctrl #(.LANES(L)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv), .in_data(in_data),
            .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
            .busy(busy)
        );

        // Transaction model: an accepted state is busy N cycles, then offered until taken
        bit           op = 1'b0;
        int           acc = 0;
        int           cyc = 0;
        logic [127:0] pend = '0;

        always @(posedge clk) begin
            cyc++;
            if (!rst_n) op = 1'b0;
            else if (op && (cyc - 1) >= acc + N && out_ready) op = 1'b0;
            else if (!op && in_valid) begin
                op   = 1'b1;
                acc  = cyc;
                pend = subcells(in_data, eff_inv(in_inv));
            end
        end

        always @(negedge clk) begin
            logic e_rdy, e_busy, e_val;
            logic [127:0] e_dat;
            if (!rst_n || !op) begin
                e_rdy = 1'b1; e_busy = 1'b0; e_val = 1'b0; e_dat = '0;
            end else if (cyc < acc + N) begin
                e_rdy = 1'b0; e_busy = 1'b1; e_val = 1'b0; e_dat = '0;
            end else begin
                e_rdy = 1'b0; e_busy = 1'b0; e_val = 1'b1; e_dat = pend;
            end
            check($sformatf("L%0d in_ready", L), 128'(in_ready), 128'(e_rdy));
            check($sformatf("L%0d busy", L), 128'(busy), 128'(e_busy));
            check($sformatf("L%0d out_valid", L), 128'(out_valid), 128'(e_val));
            check($sformatf("L%0d out_data", L), out_data, e_dat);
        end

        task automatic accept(input logic [127:0] d, input logic inv);
            int t;
            in_valid = 1'b1; in_data = d; in_inv = inv;
            for (t = 0; t < 200; t++) begin
                @(negedge clk);
                if (in_ready) break;
            end
            if (t == 200) check($sformatf("L%0d accept timeout", L), 128'(0), 128'(1));
            @(posedge clk); #2;
            in_valid = 1'b0; in_data = rand128(); in_inv = 1'($urandom);
        endtask

        task automatic measure(output int lat, output int bcnt);
            lat = 1; bcnt = 0;
            for (int t = 0; t < 100; t++) begin
                @(negedge clk);
                if (out_valid) return;
                bcnt += int'(busy);
                @(posedge clk);
                lat++;
            end
            check($sformatf("L%0d out_valid timeout", L), 128'(0), 128'(1));
        endtask

        initial begin
            int lat, bcnt, n, guard;
            bit a;
            logic [127:0] first, db;

            repeat (3) @(posedge clk);
            #1;
            check($sformatf("L%0d reset in_ready", L), 128'(in_ready), 128'(1));
            check($sformatf("L%0d reset out_valid", L), 128'(out_valid), 128'(0));
            check($sformatf("L%0d reset busy", L), 128'(busy), 128'(0));
            check($sformatf("L%0d reset out_data", L), out_data, 128'(0));
            #1 rst_n = 1'b1;

            // Known-answer vector with latency and busy length
            accept(KAT_IN, 1'b0);
            measure(lat, bcnt);
            check($sformatf("L%0d kat latency", L), 128'(lat), 128'(N + 1));
            check($sformatf("L%0d kat busy cycles", L), 128'(bcnt), 128'(N));
            check($sformatf("L%0d kat out_data", L), out_data, KAT_OUT);
            @(posedge clk); #2;

`ifdef SUBCELLS_INV_EN
            accept(KAT_OUT, 1'b1);
            measure(lat, bcnt);
            check($sformatf("L%0d inverse kat", L), out_data, KAT_IN);
`else
            accept(128'(0), 1'b1);
            measure(lat, bcnt);
            check($sformatf("L%0d inv ignored", L), out_data, ZERO_OUT);
`endif
            @(posedge clk); #2;

            // Backpressure in DONE while a new state is offered
            out_ready = 1'b0;
            accept(rand128(), 1'b0);
            measure(lat, bcnt);
            first = out_data;
            db = rand128();
            in_valid = 1'b1; in_data = db; in_inv = 1'b0;
            repeat (10) begin
                @(negedge clk);
                check($sformatf("L%0d hold out_data", L), out_data, first);
                check($sformatf("L%0d hold in_ready", L), 128'(in_ready), 128'(0));
            end
            @(posedge clk); #2 out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("L%0d ready after handshake", L), 128'(in_ready), 128'(1));
            @(posedge clk); #2 in_valid = 1'b0;
            measure(lat, bcnt);
            check($sformatf("L%0d second state", L), out_data, subcells(db, 1'b0));
            check($sformatf("L%0d second latency", L), 128'(lat), 128'(N + 1));
            @(posedge clk); #2;

            // Reset on the second cycle after accept aborts the operation
            accept(rand128(), 1'b0);
            @(posedge clk); #2 rst_n = 1'b0;
            #1;
            check($sformatf("L%0d abort out_valid", L), 128'(out_valid), 128'(0));
            check($sformatf("L%0d abort busy", L), 128'(busy), 128'(0));
            check($sformatf("L%0d abort out_data", L), out_data, 128'(0));
            check($sformatf("L%0d abort in_ready", L), 128'(in_ready), 128'(1));
            @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
            repeat (N + 3) begin
                @(negedge clk);
                check($sformatf("L%0d no output after abort", L), 128'(out_valid), 128'(0));
            end

            // 100 random states back-to-back with random consumer stalls
            n = 0; guard = 0;
            in_valid = 1'b1; in_data = rand128(); in_inv = 1'($urandom);
            while (n < 100 && guard < 20000) begin
                @(negedge clk);
                a = in_valid && in_ready;
                @(posedge clk); #2;
                guard++;
                if (a) begin
                    n++;
                    in_data = rand128(); in_inv = 1'($urandom);
                end
                out_ready = ($urandom_range(0, 3) != 0);
            end
            in_valid = 1'b0; out_ready = 1'b1;
            check($sformatf("L%0d random accepts", L), 128'(n), 128'(100));
            repeat (N + 4) @(posedge clk);
            fin = 1'b1;
        end
    end

    initial begin
        bit all_done;
        all_done = 1'b0;
        for (int c = 0; c < 60000 && !all_done; c++) begin
            @(posedge clk);
            all_done = g_dut[0].fin && g_dut[1].fin && g_dut[2].fin && g_dut[3].fin;
        end
        if (!all_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL bench timeout: stimulus did not complete, got 0 expected 1");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
